// File: rtl/exec_pkg.sv
// Shared types for the execute/writeback stage and the control unit that feeds it.
package exec_pkg;

    typedef enum logic [1:0] {
        EX_IDLE      = 2'd0,
        EX_EXECUTE   = 2'd1,
        EX_WRITEBACK = 2'd2
    } ex_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic REG_R0 = 1'b0;
    localparam logic REG_R1 = 1'b1;

    localparam int INSTR_IMM_W = 2;

    // Decoded instruction as produced by the control unit.
    typedef struct packed {
        logic                   reg_sel;
        logic                   op;
        logic [INSTR_IMM_W-1:0] imm;
    } decoded_instr_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational add/subtract-immediate ALU; carry doubles as borrow on subtract.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] imm,
    input  logic              op,
    output logic [DATA_W-1:0] res,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] w_wide;

    // The extra top bit is the carry on ADD and goes high exactly when a < imm on SUB.
    always_comb begin
        w_wide = {1'b0, a} + {1'b0, imm};
        if (op == OP_SUB) begin
            w_wide = {1'b0, a} - {1'b0, imm};
        end
    end

    assign res   = w_wide[DATA_W-1:0];
    assign carry = w_wide[DATA_W];
    assign zero  = (w_wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/exec_unit.sv
// Three-state execute/writeback stage: latch instruction, compute into alu_q, write back
// into a two-entry register file with flags and a one-cycle result strobe.
module exec_unit
    import exec_pkg::*;
#(
    parameter int                 DATA_W  = 4,
    parameter int                 IMM_W   = 2,
    parameter logic [DATA_W-1:0]  REG_RST = 4'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              register,
    input  logic              operation,
    input  logic [IMM_W-1:0]  number,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              result_reg,
    output logic              carry_o,
    output logic              zero_o,
    output logic [DATA_W-1:0] r0_o,
    output logic [DATA_W-1:0] r1_o,
    output logic              busy
);

    ex_state_t         r_state;
    logic              r_sel;
    logic              r_op;
    logic [IMM_W-1:0]  r_imm;
    logic [DATA_W-1:0] r_regs [2];
    logic [DATA_W-1:0] r_alu_res;
    logic              r_alu_carry;
    logic              r_alu_zero;
    logic [DATA_W-1:0] r_result;
    logic              r_result_reg;
    logic              r_carry;
    logic              r_zero;
    logic              r_result_valid;

    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_carry;
    logic              w_alu_zero;
    logic              w_accept;

    assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, r_imm};
    assign w_accept  = instr_valid && (r_state == EX_IDLE);

    exec_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a     (r_regs[r_sel]),
        .imm   (w_imm_ext),
        .op    (r_op),
        .res   (w_alu_res),
        .carry (w_alu_carry),
        .zero  (w_alu_zero)
    );

    // NOTE: the two-entry register file is architecturally visible, so unlike a plain
    // data memory it must be reset along with the control state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= EX_IDLE;
            r_sel          <= REG_R0;
            r_op           <= OP_ADD;
            r_imm          <= '0;
            r_regs[0]      <= REG_RST;
            r_regs[1]      <= REG_RST;
            r_alu_res      <= '0;
            r_alu_carry    <= 1'b0;
            r_alu_zero     <= 1'b0;
            r_result       <= '0;
            r_result_reg   <= 1'b0;
            r_carry        <= 1'b0;
            r_zero         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                EX_IDLE: begin
                    if (w_accept) begin
                        r_sel   <= register;
                        r_op    <= operation;
                        r_imm   <= number;
                        r_state <= EX_EXECUTE;
                    end
                end
                EX_EXECUTE: begin
                    r_alu_res   <= w_alu_res;
                    r_alu_carry <= w_alu_carry;
                    r_alu_zero  <= w_alu_zero;
                    r_state     <= EX_WRITEBACK;
                end
                EX_WRITEBACK: begin
                    r_regs[r_sel]  <= r_alu_res;
                    r_result       <= r_alu_res;
                    r_result_reg   <= r_sel;
                    r_carry        <= r_alu_carry;
                    r_zero         <= r_alu_zero;
                    r_result_valid <= 1'b1;
                    r_state        <= EX_IDLE;
                end
                default: r_state <= EX_IDLE;
            endcase
        end
    end

    assign instr_ready  = (r_state == EX_IDLE);
    assign busy         = ~instr_ready;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign result_reg   = r_result_reg;
    assign carry_o      = r_carry;
    assign zero_o       = r_zero;
    assign r0_o         = r_regs[0];
    assign r1_o         = r_regs[1];

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed register/flag values checked with immediate assertions.
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic       register;
    logic       operation;
    logic [1:0] number;
    logic       result_valid;
    logic [3:0] result;
    logic       result_reg;
    logic       carry_o;
    logic       zero_o;
    logic [3:0] r0_o;
    logic [3:0] r1_o;
    logic       busy;

    int checks = 0;
    int errors = 0;

    exec_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .register     (register),
        .operation    (operation),
        .number       (number),
        .result_valid (result_valid),
        .result       (result),
        .result_reg   (result_reg),
        .carry_o      (carry_o),
        .zero_o       (zero_o),
        .r0_o         (r0_o),
        .r1_o         (r1_o),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic [3:0] r0, input logic [3:0] r1,
                            input logic [3:0] res, input logic rreg, input logic c, input logic z);
        check({tag, "_valid"}, {7'd0, result_valid}, 8'd1);
        check({tag, "_r0"}, {4'd0, r0_o}, {4'd0, r0});
        check({tag, "_r1"}, {4'd0, r1_o}, {4'd0, r1});
        check({tag, "_res"}, {4'd0, result}, {4'd0, res});
        check({tag, "_rreg"}, {7'd0, result_reg}, {7'd0, rreg});
        check({tag, "_carry"}, {7'd0, carry_o}, {7'd0, c});
        check({tag, "_zero"}, {7'd0, zero_o}, {7'd0, z});
        check({tag, "_ready"}, {7'd0, instr_ready}, 8'd1);
    endtask

    // Present one instruction while idle, drop valid after acceptance, return in the result_valid cycle.
    task automatic issue(input string tag, input logic rs, input logic op, input logic [1:0] num,
                         input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] res,
                         input logic c, input logic z);
        check({tag, "_pre_ready"}, {7'd0, instr_ready}, 8'd1);
        register    = rs;
        operation   = op;
        number      = num;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        check({tag, "_e0_busy"}, {7'd0, busy}, 8'd1);
        step();
        check({tag, "_e1_valid"}, {7'd0, result_valid}, 8'd0);
        step();
        check_wb(tag, r0, r1, res, rs, c, z);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        register    = 1'b0;
        operation   = 1'b0;
        number      = 2'd0;
        step();
        step();
        rst_n = 1'b1;

        // Idle after reset.
        check("rst_ready", {7'd0, instr_ready}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_r0", {4'd0, r0_o}, 8'd0);
        check("rst_r1", {4'd0, r1_o}, 8'd0);
        check("rst_result", {4'd0, result}, 8'd0);
        check("rst_flags", {6'd0, carry_o, zero_o}, 8'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_valid", {7'd0, result_valid}, 8'd0);
            check("idle_ready", {7'd0, instr_ready}, 8'd1);
            check("idle_r0", {4'd0, r0_o}, 8'd0);
        end

        // ADD R0,3 with valid held high: one accept every 3 cycles.
        register    = 1'b0;
        operation   = 1'b0;
        number      = 2'd3;
        instr_valid = 1'b1;
        begin
            logic [3:0] exp_r0 [6];
            logic       exp_c  [6];
            exp_r0 = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2};
            exp_c  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int k = 0; k < 6; k++) begin
                step();
                check("b2b_e0_ready", {7'd0, instr_ready}, 8'd0);
                check("b2b_e0_valid", {7'd0, result_valid}, 8'd0);
                step();
                check("b2b_e1_ready", {7'd0, instr_ready}, 8'd0);
                check("b2b_e1_valid", {7'd0, result_valid}, 8'd0);
                step();
                if (k == 5) instr_valid = 1'b0;
                check_wb("b2b", exp_r0[k], 4'd0, exp_r0[k], 1'b0, exp_c[k], 1'b0);
            end
        end
        step();
        check("b2b_stop_valid", {7'd0, result_valid}, 8'd0);
        check("b2b_stop_ready", {7'd0, instr_ready}, 8'd1);

        // Borrow then wrap to zero on R1; R0 stays 2.
        issue("sub_r1", 1'b1, 1'b1, 2'd1, 4'd2, 4'd15, 4'd15, 1'b1, 1'b0);
        step();
        issue("add_r1", 1'b1, 1'b0, 2'd1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b1);
        step();

        // Valid toggled with other payloads while busy is ignored.
        register    = 1'b0;
        operation   = 1'b0;
        number      = 2'd1;
        instr_valid = 1'b1;
        step();
        register  = 1'b1;
        operation = 1'b1;
        number    = 2'd3;
        check("ign_e0_ready", {7'd0, instr_ready}, 8'd0);
        step();
        register  = 1'b0;
        operation = 1'b1;
        number    = 2'd2;
        check("ign_e1_ready", {7'd0, instr_ready}, 8'd0);
        step();
        instr_valid = 1'b0;
        check_wb("ign", 4'd3, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
        step();
        check("ign_after_valid", {7'd0, result_valid}, 8'd0);
        check("ign_after_ready", {7'd0, instr_ready}, 8'd1);
        check("ign_after_r0", {4'd0, r0_o}, 8'd3);

        // Reset during writeback drops the instruction.
        issue("pre_rst", 1'b0, 1'b0, 2'd2, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0);
        step();
        register    = 1'b0;
        operation   = 1'b0;
        number      = 2'd2;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        check("mid_wb_busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid", {7'd0, result_valid}, 8'd0);
        check("mid_rst_r0", {4'd0, r0_o}, 8'd0);
        check("mid_rst_ready", {7'd0, instr_ready}, 8'd1);
        check("mid_rst_result", {4'd0, result}, 8'd0);
        step();
        check("post_rst_valid", {7'd0, result_valid}, 8'd0);
        check("post_rst_r0", {4'd0, r0_o}, 8'd0);

        // RAW: ADD accepted in the result_valid cycle of the preceding SUB on R1.
        issue("raw_a", 1'b1, 1'b0, 2'd3, 4'd0, 4'd3, 4'd3, 1'b0, 1'b0);
        step();
        issue("raw_b", 1'b1, 1'b0, 2'd1, 4'd0, 4'd4, 4'd4, 1'b0, 1'b0);
        step();
        issue("raw_sub", 1'b1, 1'b1, 2'd1, 4'd0, 4'd3, 4'd3, 1'b0, 1'b0);
        issue("raw_add", 1'b1, 1'b0, 2'd2, 4'd0, 4'd5, 4'd5, 1'b0, 1'b0);
        step();
        check("raw_final_r1", {4'd0, r1_o}, 8'd5);
        check("raw_final_valid", {7'd0, result_valid}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute/writeback stage directly downstream of the control unit.
- Accepts one decoded 4-bit instruction per handshake:
  - register: 1 bit, selects R0 or R1.
  - operation: 1 bit, 0 = ADD, 1 = SUB.
  - number: 2-bit immediate.
- Performs the arithmetic on the selected register and writes the result back into a two-entry register file.
- Exposes register contents, carry/zero flags and a one-cycle result strobe to downstream consumers (display/debug, future branch logic).

Parameters:
- DATA_W, 4, register and ALU width.
- IMM_W, 2, immediate width. Zero-extended to DATA_W.
- REG_RST, 4'd0, reset value loaded into R0 and R1.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- instr_valid  input  1  control unit presents a decoded instruction.
- instr_ready  output  1  exec_unit can accept an instruction this cycle.
- register  input  1  destination/source select: 0 = R0, 1 = R1.
- operation  input  1  0 = ADD immediate, 1 = SUB immediate.
- number  input  IMM_W  immediate operand.
- result_valid  output  1  one-cycle pulse: writeback occurred.
- result  output  DATA_W  value just written. Held until the next writeback.
- result_reg  output  1  register index of the last writeback.
- carry_o  output  1  ADD: carry out. SUB: borrow.
- zero_o  output  1  last result == 0.
- r0_o  output  DATA_W  current R0.
- r1_o  output  DATA_W  current R1.
- busy  output  1  equals ~instr_ready.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = EX_IDLE; R0 = R1 = REG_RST.
  - result = 0, result_reg = 0, carry_o = 0, zero_o = 0, result_valid = 0.
  - instr_ready = 1 in the first cycle after reset.
- Reset mid-operation: the in-flight instruction is dropped with no writeback and no result_valid. Reset has priority over all other events.
- FSM states are EX_IDLE, EX_EXECUTE, EX_WRITEBACK:
  - EX_IDLE: instr_ready = 1. On instr_valid & instr_ready at edge E0: latch register, operation and number into an internal instruction register, then go to EX_EXECUTE. With no valid, stay in EX_IDLE.
  - EX_EXECUTE: instr_ready = 0. The ALU reads the selected register plus the latched immediate. At edge E1, register the ALU result and carry into alu_q, then go to EX_WRITEBACK.
  - EX_WRITEBACK: instr_ready = 0. At edge E2: write alu_q to the selected register, update result, result_reg, carry_o and zero_o, set result_valid = 1, then go to EX_IDLE.
- result_valid is high exactly for the cycle following E2 and is 0 otherwise.
- Latency and throughput:
  - Accept at E0 -> register file updated and result_valid high after E2 (2 cycles).
  - Maximum throughput is one instruction per 3 cycles.
  - A new instruction may be accepted in the same cycle result_valid is high.
- instr_valid while instr_ready = 0 is ignored. The upstream must hold the instruction until it sees ready; exec_unit does not buffer it.
- Arithmetic rules:
  - Immediate is zero-extended to DATA_W.
  - ADD: {carry, res} = reg + imm, with a DATA_W+1-bit sum; the result wraps modulo 2^DATA_W.
  - SUB: res = reg - imm modulo 2^DATA_W; carry = 1 iff reg < imm (borrow).
  - zero = (res == 0).
- Read-after-write: an instruction accepted in the result_valid cycle reads the already-updated register. The write at E2 precedes the read in EX_EXECUTE, so no forwarding is needed.
- Only the selected register changes on writeback. The other register is stable.
- Flags hold their value between writebacks.

Decomposition:
- Package exec_pkg holds:
  - typedef enum logic [1:0] ex_state_t {EX_IDLE, EX_EXECUTE, EX_WRITEBACK}.
  - localparams OP_ADD = 1'b0, OP_SUB = 1'b1, REG_R0 = 1'b0, REG_R1 = 1'b1.
  - A packed struct decoded_instr_t {reg_sel, op, imm}, shared with the control unit.
- Sub-module exec_alu: purely combinational. Inputs a[DATA_W], imm[DATA_W], op. Outputs res[DATA_W], carry, zero.
- The FSM, instruction latch and register file stay in exec_unit.

Test Plan:
- Reset release, then hold instr_valid = 0 for 5 cycles -> r0_o = r1_o = 0, flags 0, result_valid never high, instr_ready = 1.
- ADD R0, 3 issued four times back-to-back, with valid held high -> accepts spaced 3 cycles apart:
  - R0 goes 3, 6, 9, 12; result_valid pulses each time exactly 2 cycles after acceptance; carry 0.
  - A fifth ADD R0, 3 -> R0 = 15. A sixth -> R0 = 2, carry_o = 1, zero_o = 0.
- SUB R1, 1 from R1 = 0 -> R1 = 15, carry_o = 1 (borrow). Then ADD R1, 1 -> R1 = 0, zero_o = 1, carry_o = 1. Throughout, R0 is unchanged.
- instr_valid toggled during EX_EXECUTE/EX_WRITEBACK with differing payloads -> ignored. Only the originally accepted instruction is written back.
- rst_n low during EX_WRITEBACK of ADD R0, 2 (R0 = 5) -> no result_valid. Next cycle R0 = 0, state EX_IDLE, instr_ready = 1.
- ADD R1, 2 accepted in the cycle its predecessor SUB R1, 1 (R1: 4 -> 3) shows result_valid -> final R1 = 5, confirming no RAW hazard.
